// File: rtl/tpu_fp8_pkg.sv
// Shared Float8 constants, mode encodings and helpers for the TPU vector multiplier.
// The saturating overflow value lives here and is used when TPU_VEC_MULT_SAT_EN is defined.
package tpu_fp8_pkg;

    localparam int unsigned FP8_W     = 8;
    localparam int unsigned FP8_EXP_W = 4;
    localparam int unsigned FP8_MAN_W = FP8_W - 1 - FP8_EXP_W;
    localparam int unsigned FP8_BIAS  = 7;

    typedef enum logic {
        MODE_ELEM  = 1'b0,
        MODE_BCAST = 1'b1
    } mode_e;

    // Magnitude of a saturated element: all-ones exponent and mantissa.
    localparam logic [FP8_W-2:0] FP8_SAT_MAG = '1;

    // Exponent field of zero means zero; subnormals are flushed.
    function automatic logic fp8_is_zero(input logic [FP8_W-2:0] mag, input int unsigned exp_w);
        return (mag >> (FP8_W - 1 - exp_w)) == '0;
    endfunction

endpackage

// File: rtl/tpu_fp8_mult_lane.sv
// One Float8 multiplier lane: S1 holds sign/exponent sum/significand product, S2 the normalised
// element and overflow bit. Overflow saturates when TPU_VEC_MULT_SAT_EN is defined, else wraps.
module tpu_fp8_mult_lane
    import tpu_fp8_pkg::*;
#(
    parameter int unsigned EXP_W = FP8_EXP_W,
    parameter int unsigned BIAS  = FP8_BIAS
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       s1_load_i,
    input  logic       s2_load_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] res_o,
    output logic       ovf_o
);

    localparam int unsigned ManW  = FP8_W - 1 - EXP_W;
    localparam int unsigned SigW  = ManW + 1;
    localparam int unsigned ProdW = 2 * SigW;
    localparam int unsigned ExpXW = EXP_W + 2;

    localparam logic signed [ExpXW-1:0] BiasX  = ExpXW'(BIAS);
    localparam logic signed [ExpXW-1:0] ExpMin = ExpXW'(1);
    localparam logic signed [ExpXW-1:0] ExpMax = ExpXW'((1 << EXP_W) - 1);

    // Stage 1: field split, sign, biased exponent sum and significand product.
    logic [EXP_W-1:0]        exp_a, exp_b;
    logic [ManW-1:0]         man_a, man_b;
    logic                    s1_sign_d, s1_sign_q;
    logic                    s1_zero_d, s1_zero_q;
    logic signed [ExpXW-1:0] s1_exp_d, s1_exp_q;
    logic [ProdW-1:0]        s1_prod_d, s1_prod_q;

    always_comb begin
        exp_a     = a_i[FP8_W-2 -: EXP_W];
        exp_b     = b_i[FP8_W-2 -: EXP_W];
        man_a     = a_i[ManW-1:0];
        man_b     = b_i[ManW-1:0];
        s1_sign_d = a_i[FP8_W-1] ^ b_i[FP8_W-1];
        s1_zero_d = fp8_is_zero(a_i[FP8_W-2:0], EXP_W) | fp8_is_zero(b_i[FP8_W-2:0], EXP_W);
        s1_exp_d  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BiasX;
        s1_prod_d = ProdW'({1'b1, man_a}) * ProdW'({1'b1, man_b});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b1;
            s1_exp_q  <= '0;
            s1_prod_q <= '0;
        end else if (s1_load_i) begin
            s1_sign_q <= s1_sign_d;
            s1_zero_q <= s1_zero_d;
            s1_exp_q  <= s1_exp_d;
            s1_prod_q <= s1_prod_d;
        end
    end

    // Stage 2: normalise a product in [1,4), truncate, then resolve underflow/overflow.
    logic                    carry;
    logic signed [ExpXW-1:0] exp_n;
    logic [ManW-1:0]         man_n;
    logic [7:0]              s2_res_d, s2_res_q;
    logic                    s2_ovf_d, s2_ovf_q;

    always_comb begin
        carry    = s1_prod_q[ProdW-1];
        exp_n    = s1_exp_q + $signed({{(ExpXW-1){1'b0}}, carry});
        man_n    = ManW'(s1_prod_q >> (carry ? SigW : ManW));
        s2_ovf_d = 1'b0;
        s2_res_d = {s1_sign_q, exp_n[EXP_W-1:0], man_n};
        if (s1_zero_q || (exp_n < ExpMin)) begin
            s2_res_d = {s1_sign_q, {(FP8_W-1){1'b0}}};
        end else if (exp_n > ExpMax) begin
            s2_ovf_d = 1'b1;
`ifdef TPU_VEC_MULT_SAT_EN
            s2_res_d = {s1_sign_q, FP8_SAT_MAG};
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_res_q <= '0;
            s2_ovf_q <= 1'b0;
        end else if (s2_load_i) begin
            s2_res_q <= s2_res_d;
            s2_ovf_q <= s2_ovf_d;
        end
    end

    assign res_o = s2_res_q;
    assign ovf_o = s2_ovf_q;

endmodule

// File: rtl/tpu_vec_mult_pipe.sv
// Two-stage LANES-wide Float8 vector multiplier with valid/ready flow control, broadcast mode
// and sticky overflow. Define TPU_VEC_MULT_SAT_EN to saturate overflowing lanes.
module tpu_vec_mult_pipe
    import tpu_fp8_pkg::*;
#(
    parameter int unsigned LANES = 32,
    parameter int unsigned EXP_W = FP8_EXP_W,
    parameter int unsigned BIAS  = FP8_BIAS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [LANES*8-1:0] data_in1,
    input  logic [LANES*8-1:0] data_in2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*8-1:0] data_out,
    output logic               out_ovf,
    output logic               ovf_sticky,
    input  logic               ovf_clr
);

    logic s1_v_d, s1_v_q;
    logic s2_v_d, s2_v_q;
    logic s1_load, s2_load;
    logic s1_en, s2_en;
    logic ovf_sticky_d, ovf_sticky_q;

    logic [LANES*8-1:0] b_sel;
    logic [LANES-1:0]   lane_ovf;

    // A stage may load whenever it is empty or its content moves on this cycle.
    always_comb begin
        s2_load = !s2_v_q || out_ready;
        s1_load = !s1_v_q || s2_load;
        s1_en   = s1_load && in_valid;
        s2_en   = s2_load && s1_v_q;
        s1_v_d  = s1_load ? in_valid : s1_v_q;
        s2_v_d  = s2_load ? s1_v_q : s2_v_q;
    end

    // Broadcast is resolved before S1, so mode travels with its own beat.
    always_comb begin
        b_sel = data_in2;
        if (mode == MODE_BCAST) begin
            b_sel = {LANES{data_in2[7:0]}};
        end
    end

    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
        if (s2_v_q && out_ready && (|lane_ovf)) begin
            ovf_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            s1_v_q       <= s1_v_d;
            s2_v_q       <= s2_v_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        tpu_fp8_mult_lane #(
            .EXP_W(EXP_W),
            .BIAS (BIAS)
        ) u_lane (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .s1_load_i(s1_en),
            .s2_load_i(s2_en),
            .a_i      (data_in1[8*i +: 8]),
            .b_i      (b_sel[8*i +: 8]),
            .res_o    (data_out[8*i +: 8]),
            .ovf_o    (lane_ovf[i])
        );
    end

    assign in_ready   = s1_load;
    assign out_valid  = s2_v_q;
    assign out_ovf    = s2_v_q && (|lane_ovf);
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_tpu_vec_mult_pipe.sv
// Scoreboard bench for tpu_vec_mult_pipe (E4M3, 32 lanes) using directed vectors.
module tb_tpu_vec_mult_pipe;

    localparam int L = 32;
    localparam int W = L * 8;

`ifdef TPU_VEC_MULT_SAT_EN
    localparam logic [7:0] OVF_LANE = 8'h7F;
`else
    localparam logic [7:0] OVF_LANE = 8'h07;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode = 1'b0;
    logic [W-1:0] data_in1 = '0;
    logic [W-1:0] data_in2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] data_out;
    logic         out_ovf;
    logic         ovf_sticky;
    logic         ovf_clr = 1'b0;

    tpu_vec_mult_pipe #(.LANES(L), .EXP_W(4), .BIAS(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .data_in1  (data_in1),
        .data_in2  (data_in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_ovf   (out_ovf),
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    exp_t head;
    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    logic saw_block = 1'b0;
    logic prev_stall = 1'b0;

    function automatic logic [W-1:0] fill(input logic [7:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < L; i++) r[8*i +: 8] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] set_lane(input logic [W-1:0] vec, input int idx,
                                              input logic [7:0] v);
        logic [W-1:0] r;
        r = vec;
        r[8*idx +: 8] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Issue one beat; the expectation is queued on the cycle the block accepts it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W-1:0] exp_d, input logic exp_o);
        int   t;
        logic done;
        exp_t e;
        t = 0;
        done = 1'b0;
        data_in1 = a;
        data_in2 = b;
        mode = m;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.d = exp_d;
                e.o = exp_o;
                exp_q.push_back(e);
                done = 1'b1;
            end else if (++t > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", t);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending beats, expected 0", exp_q.size());
        end
    endtask

    // Monitor: compares every accepted output beat against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("stall_valid_hold", W'(out_valid), W'(1));
                if (in_valid && !in_ready) saw_block = 1'b1;
                if (out_valid && !out_ready && exp_q.size() != 0) begin
                    head = exp_q[0];
                    chk("stall_data", data_out, head.d);
                    chk("stall_ovf", W'(out_ovf), W'(head.o));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %h, expected no beat", data_out);
                    end else begin
                        head = exp_q.pop_front();
                        popped++;
                        chk("data", data_out, head.d);
                        chk("ovf", W'(out_ovf), W'(head.o));
                    end
                end
                prev_stall = out_valid && !out_ready;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b, e;
        int p0;

        #12;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_data_out", data_out, '0);
        chk("rst_out_ovf", W'(out_ovf), W'(0));
        chk("rst_sticky", W'(ovf_sticky), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.5 * 1.5 = 2.25, two-cycle latency
        send(fill(8'h3C), fill(8'h3C), 1'b0, fill(8'h41), 1'b0);
        chk("lat_cycle1", W'(out_valid), W'(0));
        @(posedge clk);
        #1;
        chk("lat_cycle2", W'(out_valid), W'(1));
        drain();

        // Broadcast b[0]=2.0, then an elementwise beat on the same operands
        b = set_lane(fill(8'h00), 0, 8'h40);
        send(fill(8'h38), b, 1'b1, fill(8'h40), 1'b0);
        send(fill(8'h38), b, 1'b0, set_lane(fill(8'h00), 0, 8'h40), 1'b0);
        drain();

        // Lane 5 overflows
        a = set_lane(fill(8'h38), 5, 8'h7F);
        b = set_lane(fill(8'h38), 5, 8'h40);
        send(a, b, 1'b0, set_lane(fill(8'h38), 5, OVF_LANE), 1'b1);
        drain();
        chk("sticky_set", W'(ovf_sticky), W'(1));
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("sticky_clr", W'(ovf_sticky), W'(0));

        // Underflow, zero operand, subnormal flush, largest finite, negative product
        a = fill(8'h38);
        b = fill(8'h38);
        e = fill(8'h38);
        a = set_lane(a, 0, 8'h08); b = set_lane(b, 0, 8'h88); e = set_lane(e, 0, 8'h80);
        a = set_lane(a, 1, 8'h00); b = set_lane(b, 1, 8'h7F); e = set_lane(e, 1, 8'h00);
        a = set_lane(a, 2, 8'h05); b = set_lane(b, 2, 8'h40); e = set_lane(e, 2, 8'h00);
        a = set_lane(a, 3, 8'h7F); b = set_lane(b, 3, 8'h38); e = set_lane(e, 3, 8'h7F);
        a = set_lane(a, 4, 8'hBC); b = set_lane(b, 4, 8'h3C); e = set_lane(e, 4, 8'hC1);
        send(a, b, 1'b0, e, 1'b0);
        drain();
        chk("sticky_quiet", W'(ovf_sticky), W'(0));

        // Six back-to-back beats (1+k/8)*2.0 with a three-cycle output stall
        p0 = popped;
        saw_block = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send(fill(8'h38 + 8'(k)), fill(8'h40), 1'b0, fill(8'h40 + 8'(k)), 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", W'(popped - p0), W'(6));
        chk("stream_backpressure", W'(saw_block), W'(1));

        // Reset while both stages hold overflowing beats
        send(a, b, 1'b0, e, 1'b0);
        a = set_lane(fill(8'h38), 5, 8'h7F);
        b = set_lane(fill(8'h38), 5, 8'h40);
        send(a, b, 1'b0, set_lane(fill(8'h38), 5, OVF_LANE), 1'b1);
        drain();
        out_ready = 1'b0;
        send(a, b, 1'b0, set_lane(fill(8'h38), 5, OVF_LANE), 1'b1);
        send(a, b, 1'b0, set_lane(fill(8'h38), 5, OVF_LANE), 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_ovf", W'(out_ovf), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", W'(out_valid), W'(0));
        chk("mid_rst_out_ovf", W'(out_ovf), W'(0));
        chk("mid_rst_sticky", W'(ovf_sticky), W'(0));
        chk("mid_rst_data", data_out, '0);
        chk("mid_rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clear and overflowing accept on the same edge: set wins
        send(a, b, 1'b0, set_lane(fill(8'h38), 5, OVF_LANE), 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("parked_valid", W'(out_valid), W'(1));
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("sticky_set_wins", W'(ovf_sticky), W'(1));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
